counter_sched: RTL

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched.sv | 106 ++++++++++
 1 files changed

// File: rtl/counter_sched.sv
// Two-requester scheduler sharing one up-counter: grant, count to the owner's target, pulse done.
// Define COUNTER_SCHED_PRIORITY_EN for fixed priority (req[0] wins); default is round-robin.
module counter_sched #(
   parameter int Size = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      req,
   input  logic [Size-1:0] target0,
   input  logic [Size-1:0] target1,
   input  logic            abort,
   output logic [1:0]      gnt,
   output logic [Size-1:0] count,
   output logic            busy,
   output logic [1:0]      done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [Size-1:0] count_q, count_d;
   logic [Size-1:0] tgt_q, tgt_d;
   logic            win;

`ifdef COUNTER_SCHED_PRIORITY_EN
   always_comb win = ~req[0];
`else
   logic last_q, last_d;

   // The previous owner yields only when both requesters contend.
   always_comb begin
      if (req == 2'b11) win = ~last_q;
      else              win = req[1];
   end

   always_comb begin
      last_d = last_q;
      if ((state_q == COUNT && abort) || state_q == DONE) last_d = gnt_q[1];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) last_q <= 1'b1;
      else        last_q <= last_d;
   end
`endif

   always_comb begin
      // NOTE: every next-state value gets a default first so no path infers a latch.
      state_d = state_q;
      gnt_d   = gnt_q;
      count_d = count_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = COUNT;
               gnt_d   = win ? 2'b10 : 2'b01;
               tgt_d   = win ? target1 : target0;
               count_d = '0;
            end
         end
         COUNT: begin
            if (abort) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               count_d = '0;
            end else if (count_q == tgt_q) begin
               state_d = DONE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         count_q <= '0;
         tgt_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q <= state_d;
         gnt_q   <= gnt_d;
         count_q <= count_d;
         tgt_q   <= tgt_d;
      end
   end

   assign gnt   = gnt_q;
   assign count = count_q;
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE) ? gnt_q : 2'b00;

endmodule
